byte_receiver: RTL and testbench
================================

# byte_receiver

Serial-to-parallel byte assembler, the receive-side counterpart of the byte transmitter in the I2C FNV hasher datapath. While `enable` is high it samples one bit per clock and assembles a byte. On the 8th bit it hands the byte to a one-deep holding register presented on a valid/ready interface to the hasher core. Partial bytes are discarded when `enable` drops.

## Interface
- `LSB_FIRST`, default 1: 1 means the first sampled bit is bit 0, matching the transmitter; 0 means the first sampled bit is bit 7.
- `clk`  input  1  clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high.
- `enable`  input  1  bit-sample qualifier; low clears the bit counter.
- `in`  input  1  serial data bit, sampled when `enable`=1.
- `out`  output  8  held byte; valid only while `out_valid`=1.
- `out_valid`  output  1  holding register full.
- `out_ready`  input  1  consumer accepts `out` when `out_valid`&`out_ready`.
- `busy`  output  1  high while a partial byte is in progress (bit count != 0).
- `overrun`  output  1  sticky overrun flag (see Configuration).
- `overrun_clear`  input  1  clears `overrun`.

## Operation
- Internal state: shift register `sr[7:0]`, bit counter `cnt[2:0]`, holding register `hold[7:0]`, `full` flag.
- Sample cycle (`enable`=1):
  - `in` is written into `sr` at index `cnt` (LSB_FIRST=1) or `7-cnt` (LSB_FIRST=0).
  - `cnt` increments, wrapping 7→0.
- Completion cycle: sample cycle with `cnt`=7. The assembled byte (`sr` with the current bit merged) is the candidate for `hold`.
- Load rule on a completion cycle:
  - If `full`=0, or `full`=1 with `out_ready`=1 in the same cycle: the candidate loads into `hold` and `full` becomes 1.
  - Otherwise the candidate is dropped and the overrun event fires. `hold` keeps the old byte.
- Pop: `full`&`out_ready` with no completion in that cycle clears `full`.
- `enable`=0 cycle: `cnt` is set to 0 and the partial byte is abandoned. `sr` contents become don't-care. `hold` and `full` are unaffected.
- Bit width: `cnt` counts modulo 8. A byte never spans an `enable` low gap.
- States are implicit in the counter: IDLE (`cnt`=0), SHIFTING (`cnt` 1..7). `busy` = (`cnt`!=0).

## Timing
- Reset values: `out`=0x00, `out_valid`=0, `busy`=0, `overrun`=0, `cnt`=0, `sr`=0x00.
- Latency: `out_valid` rises on the clock edge that samples the 8th bit, so it is visible the cycle after the completion cycle.
- `out` is stable from `out_valid` rise until the pop edge. It changes only on a load.
- Back-to-back operation: with `out_ready` tied high, continuous `enable` delivers one byte every 8 cycles. `out_valid` pulses for 1 cycle, or stays high if the next completion coincides with the pop.
- Simultaneous `overrun_clear` and overrun event: the set wins and `overrun` stays 1.
- Reset mid-byte discards `sr` and `cnt`, and clears `hold`/`full`, on the same edge.
- `out_ready` while `out_valid`=0 is ignored.

## Configuration
- `BYTE_RECEIVER_OVERRUN_EN` defined: an overrun event sets `overrun` on the next edge. It stays set until `overrun_clear` or `reset`.
- `BYTE_RECEIVER_OVERRUN_EN` undefined:
  - `overrun` is tied to 0 and `overrun_clear` is ignored.
  - The drop-on-full behaviour is unchanged.

## Structure
- Shared package `byte_pkg`:
  - `BYTE_WIDTH`=8.
  - `BIT_CNT_W`=3.
  - `typedef logic [BYTE_WIDTH-1:0] byte_t`.
  - The package is shared with the transmitter.
- One sub-module, `byte_hold_reg`: one-deep valid/ready holding register with load/pop and a `drop` output that drives the overrun logic.
- Shift and count logic stay in `byte_receiver`.

## Test plan
- Reset, then `enable`=1 with LSB_FIRST=1 and bits 1,0,1,0,0,1,0,1 → `out`=0xA5 and `out_valid`=1 the cycle after the 8th bit; `busy`=1 during bits 2–8.
- LSB_FIRST=0 with the same bit sequence → `out`=0xA5 read MSB-first, i.e. bits 10100101 = 0xA5. Then send 1,1,0,0,0,0,0,0 → `out`=0xC0.
- `enable` low after 5 bits, then a full 0x3C → `out`=0x3C with no corruption from the partial byte.
- `out_ready`=0, send 0x11 then 0x22 → `out` stays 0x11 and `overrun`=1 (macro on) or 0 (macro off). `overrun_clear` → 0.
- `out_ready` asserted on the exact completion cycle of 0x22 while 0x11 is held → 0x11 pops, `out`=0x22, `out_valid` stays high, no overrun.
- `reset` asserted at bit 4 → all outputs at reset values the next cycle; a subsequent 0xFF is received correctly.

Source files
------------

// File: rtl/byte_pkg.sv
// byte_pkg: widths and byte type shared by the byte transmitter and receiver
package byte_pkg;
    localparam int BYTE_WIDTH = 8;
    localparam int BIT_CNT_W = 3;
    typedef logic [BYTE_WIDTH-1:0] byte_t;
    typedef logic [BIT_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/byte_receiver_if.sv
// byte_receiver_if: valid/ready byte stream from the receiver to the hasher core
interface byte_receiver_if;
    import byte_pkg::*;
    byte_t data;
    logic valid;
    logic ready;
    modport master(output data, output valid, input ready);
    modport slave(input data, input valid, output ready);
endinterface

// File: rtl/byte_hold_reg.sv
// byte_hold_reg: one-deep valid/ready holding register; drop flags a load refused while full
module byte_hold_reg
    import byte_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  byte_t data_i,
    input  logic  pop_i,
    output byte_t data_o,
    output logic  valid_o,
    output logic  drop_o
);
    byte_t hold_q, hold_d;
    logic  full_q, full_d;

    assign drop_o  = load_i & full_q & ~pop_i;
    assign data_o  = hold_q;
    assign valid_o = full_q;

    // a load wins over a pop in the same cycle; a pop with no load empties the register
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (load_i && (!full_q || pop_i)) begin
            hold_d = data_i;
            full_d = 1'b1;
        end else if (full_q && pop_i) begin
            full_d = 1'b0;
        end
    end

    // holding register state
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end
endmodule

// File: rtl/byte_receiver.sv
// byte_receiver: serial-to-parallel byte assembler; BYTE_RECEIVER_OVERRUN_EN enables the sticky overrun flag
module byte_receiver
    import byte_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic in_i,
    output logic busy_o,
    output logic overrun_o,
    input  logic overrun_clear_i,
    byte_receiver_if.master out_if
);
    byte_t sr_q, sr_d;
    cnt_t  cnt_q, cnt_d;
    cnt_t  idx;
    logic  complete;
    logic  drop;
    logic  valid;
    byte_t data;

    assign idx      = LSB_FIRST ? cnt_q : cnt_t'(BYTE_WIDTH - 1) - cnt_q;
    assign complete = enable_i && (cnt_q == '1);
    assign busy_o   = (cnt_q != '0);

    // merge the sampled bit and advance the counter; enable low abandons the partial byte
    always_comb begin
        sr_d  = sr_q;
        cnt_d = '0;
        if (enable_i) begin
            sr_d[idx] = in_i;
            cnt_d     = cnt_q + 1'b1;
        end
    end

    // shift register and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    byte_hold_reg u_hold (
        .clk    (clk),
        .reset  (reset),
        .load_i (complete),
        .data_i (sr_d),
        .pop_i  (out_if.ready),
        .data_o (data),
        .valid_o(valid),
        .drop_o (drop)
    );

    assign out_if.data  = data;
    assign out_if.valid = valid;

`ifdef BYTE_RECEIVER_OVERRUN_EN
    logic ovr_q;

    // sticky overrun; a new drop outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) ovr_q <= 1'b0;
        else ovr_q <= drop | (ovr_q & ~overrun_clear_i);
    end

    assign overrun_o = ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = drop ^ overrun_clear_i;
    assign overrun_o  = 1'b0;
`endif
endmodule

// File: tb/tb_byte_receiver.sv
// tb_byte_receiver: LSB-first and MSB-first receivers against a bit-queue reference model
module tb_byte_receiver;
    logic clk = 1'b0;
    logic reset, enable, in_bit, ovr_clr;
    logic busy1, busy0, ovr1, ovr0;
    int total = 0;
    int bad = 0;

    byte_receiver_if if1 ();
    byte_receiver_if if0 ();

    always #5 clk = ~clk;

    byte_receiver #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable_i(enable), .in_i(in_bit),
        .busy_o(busy1), .overrun_o(ovr1), .overrun_clear_i(ovr_clr), .out_if(if1)
    );
    byte_receiver #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable_i(enable), .in_i(in_bit),
        .busy_o(busy0), .overrun_o(ovr0), .overrun_clear_i(ovr_clr), .out_if(if0)
    );

    // reference model: bits collected since the last enable-low gap, plus the holding register
    logic m_bits[$];
    logic [7:0] m_hold1, m_hold0;
    logic m_full, m_ovr;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic en, input logic b, input logic rdy, input logic clr);
        logic comp, drop;
        logic [7:0] c1, c0;
        comp = 1'b0;
        c1 = 8'h00;
        c0 = 8'h00;
        if (rst) begin
            m_bits.delete();
            m_full = 1'b0;
            m_hold1 = 8'h00;
            m_hold0 = 8'h00;
            m_ovr = 1'b0;
            return;
        end
        if (en) begin
            m_bits.push_back(b);
            if (m_bits.size() == 8) begin
                comp = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    c1 = c1 + (8'(m_bits[i]) << i);
                    c0 = c0 + (8'(m_bits[i]) << (7 - i));
                end
                m_bits.delete();
            end
        end else begin
            m_bits.delete();
        end
        drop = comp && m_full && !rdy;
        if (comp && (!m_full || rdy)) begin
            m_hold1 = c1;
            m_hold0 = c0;
            m_full = 1'b1;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
`ifdef BYTE_RECEIVER_OVERRUN_EN
        m_ovr = drop || (m_ovr && !clr);
`else
        m_ovr = 1'b0 & drop & clr;
`endif
    endtask

    task automatic step(input logic rst, input logic en, input logic b, input logic rdy, input logic clr);
        reset = rst;
        enable = en;
        in_bit = b;
        if1.ready = rdy;
        if0.ready = rdy;
        ovr_clr = clr;
        @(posedge clk);
        model(rst, en, b, rdy, clr);
        #1;
        chk("out_lsb", if1.data, m_hold1);
        chk("out_msb", if0.data, m_hold0);
        chk("valid_lsb", 8'(if1.valid), 8'(m_full));
        chk("valid_msb", 8'(if0.valid), 8'(m_full));
        chk("busy_lsb", 8'(busy1), 8'(m_bits.size() != 0));
        chk("busy_msb", 8'(busy0), 8'(m_bits.size() != 0));
        chk("ovr_lsb", 8'(ovr1), 8'(m_ovr));
        chk("ovr_msb", 8'(ovr0), 8'(m_ovr));
    endtask

    // drives v[0] first; rdy_last applies on the completion cycle only
    task automatic send(input logic [7:0] v, input logic rdy, input logic rdy_last);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, v[i], (i == 7) ? rdy_last : rdy, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_out", if1.data, 8'h00);
        chk("reset_valid", 8'(if1.valid), 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        chk("a5_lsb", if1.data, 8'hA5);
        chk("a5_msb", if0.data, 8'hA5);
        chk("a5_valid", 8'(if1.valid), 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        chk("c0_msb", if0.data, 8'hC0);
        chk("c0_lsb", if1.data, 8'h03);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        chk("partial_3c", if1.data, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        chk("ovr_keep", if1.data, 8'h11);
`ifdef BYTE_RECEIVER_OVERRUN_EN
        chk("ovr_set", 8'(ovr1), 8'h01);
`else
        chk("ovr_off", 8'(ovr1), 8'h00);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", 8'(ovr1), 8'h00);
        send(8'h22, 1'b0, 1'b1);
        chk("coincide_out", if1.data, 8'h22);
        chk("coincide_valid", 8'(if1.valid), 8'h01);
        chk("coincide_ovr", 8'(ovr1), 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_busy", 8'(busy1), 8'h00);
        chk("rst_valid", 8'(if1.valid), 8'h00);
        send(8'hFF, 1'b0, 1'b0);
        chk("ff_out", if1.data, 8'hFF);
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
